asrv32_writeback: RTL



---
 rtl/asrv32_writeback.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/asrv32_writeback.sv
// asrv32 write-back / commit stage: rd formatting, next-PC resolution, retire pulse, load stall.
// Optional commit trace port enabled by defining ASRV32_WB_TRACE_EN.

`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 11
`define LOAD   0
`define STORE  1
`define BRANCH 2
`define JAL    3
`define JALR   4
`define LUI    5
`define AUIPC  6
`define SYSTEM 7
`define RTYPE  8
`define ITYPE  9
`define FENCE  10
`endif

module asrv32_writeback #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_wb_stage_en,
    input  logic [`OPCODE_WIDTH-1:0] i_opcode,
    input  logic [2:0]               i_funct3,
    input  logic [31:0]              i_pc,
    input  logic [31:0]              i_imm,
    input  logic [31:0]              i_alu_result,
    input  logic                     i_branch_taken,
    input  logic [4:0]               i_rd_addr,
    input  logic [31:0]              i_csr_out,
    input  logic [31:0]              i_load_data,
    input  logic                     i_load_ack,
    input  logic                     i_go_to_trap,
    input  logic                     i_return_from_trap,
    input  logic [31:0]              i_trap_address,
    input  logic [31:0]              i_return_address,
    output logic                     o_rd_wr_en,
    output logic [4:0]               o_rd_addr,
    output logic [31:0]              o_rd_data,
    output logic [31:0]              o_next_pc,
    output logic                     o_pc_load,
    output logic                     o_minstret_inc,
`ifdef ASRV32_WB_TRACE_EN
    output logic                     o_trace_valid,
    output logic [31:0]              o_trace_pc,
    output logic                     o_trace_trap,
`endif
    output logic                     o_stall
);

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } state_t;

    typedef struct packed {
        logic [`OPCODE_WIDTH-1:0] opcode;
        logic [2:0]               funct3;
        logic [31:0]              pc;
        logic [31:0]              imm;
        logic [31:0]              alu;
        logic                     br_taken;
        logic [4:0]               rd;
        logic [31:0]              csr;
        logic                     trap;
        logic                     mret;
        logic [31:0]              trap_addr;
        logic [31:0]              ret_addr;
    } ops_t;

    state_t      state_q;
    ops_t        op_q;
    ops_t        op_in;
    ops_t        op_cur;

    logic        load_defer;
    logic        commit_go;
    logic [31:0] pc_plus4;
    logic [31:0] pc_plus_imm;
    logic [31:0] next_pc_d;
    logic [31:0] rd_data_d;
    logic        rd_valid;
    logic        rd_wr_en_d;
    logic [31:0] load_val;

    function automatic logic [31:0] load_extract(input logic [2:0]  funct3,
                                                 input logic [1:0]  offset,
                                                 input logic [31:0] word);
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        byte_v = word[8*offset +: 8];
        half_v = offset[1] ? word[31:16] : word[15:0];
        case (funct3)
            3'd0:    load_extract = {{24{byte_v[7]}}, byte_v};
            3'd1:    load_extract = {{16{half_v[15]}}, half_v};
            3'd2:    load_extract = word;
            3'd4:    load_extract = {24'd0, byte_v};
            3'd5:    load_extract = {16'd0, half_v};
            default: load_extract = 32'd0;
        endcase
    endfunction

    always_comb begin
        op_in.opcode    = i_opcode;
        op_in.funct3    = i_funct3;
        op_in.pc        = i_pc;
        op_in.imm       = i_imm;
        op_in.alu       = i_alu_result;
        op_in.br_taken  = i_branch_taken;
        op_in.rd        = i_rd_addr;
        op_in.csr       = i_csr_out;
        op_in.trap      = i_go_to_trap;
        op_in.mret      = i_return_from_trap;
        op_in.trap_addr = i_trap_address;
        op_in.ret_addr  = i_return_address;
    end

    // In WAIT_LOAD the commit is computed from the operands captured with the token.
    assign op_cur     = (state_q == WAIT_LOAD) ? op_q : op_in;
    assign load_defer = i_opcode[`LOAD] && !i_go_to_trap;
    assign commit_go  = ((state_q == IDLE) && i_wb_stage_en && !load_defer) ||
                        ((state_q == WAIT_LOAD) && i_load_ack);

    assign pc_plus4    = op_cur.pc + 32'd4;
    assign pc_plus_imm = op_cur.pc + op_cur.imm;
    assign load_val    = load_extract(op_cur.funct3, op_cur.alu[1:0], i_load_data);

    always_comb begin
        next_pc_d = pc_plus4;
        if (op_cur.trap)
            next_pc_d = op_cur.trap_addr;
        else if (op_cur.mret)
            next_pc_d = op_cur.ret_addr;
        else if (op_cur.opcode[`JAL])
            next_pc_d = pc_plus_imm;
        else if (op_cur.opcode[`JALR])
            next_pc_d = {op_cur.alu[31:1], 1'b0};
        else if (op_cur.opcode[`BRANCH] && op_cur.br_taken)
            next_pc_d = pc_plus_imm;
    end

    always_comb begin
        rd_data_d = 32'd0;
        rd_valid  = 1'b0;
        if (op_cur.opcode[`LUI]) begin
            rd_data_d = op_cur.imm;
            rd_valid  = 1'b1;
        end else if (op_cur.opcode[`AUIPC]) begin
            rd_data_d = pc_plus_imm;
            rd_valid  = 1'b1;
        end else if (op_cur.opcode[`JAL] || op_cur.opcode[`JALR]) begin
            rd_data_d = pc_plus4;
            rd_valid  = 1'b1;
        end else if (op_cur.opcode[`SYSTEM] && (op_cur.funct3 != 3'd0)) begin
            rd_data_d = op_cur.csr;
            rd_valid  = 1'b1;
        end else if (op_cur.opcode[`RTYPE] || op_cur.opcode[`ITYPE]) begin
            rd_data_d = op_cur.alu;
            rd_valid  = 1'b1;
        end else if (op_cur.opcode[`LOAD]) begin
            rd_data_d = load_val;
            rd_valid  = 1'b1;
        end
        rd_wr_en_d = rd_valid && (op_cur.rd != 5'd0) && !op_cur.trap;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q        <= IDLE;
            op_q           <= '0;
            o_rd_wr_en     <= 1'b0;
            o_rd_addr      <= 5'd0;
            o_rd_data      <= 32'd0;
            o_next_pc      <= PC_RESET;
            o_pc_load      <= 1'b0;
            o_minstret_inc <= 1'b0;
            o_stall        <= 1'b0;
`ifdef ASRV32_WB_TRACE_EN
            o_trace_valid  <= 1'b0;
            o_trace_pc     <= 32'd0;
            o_trace_trap   <= 1'b0;
`endif
        end else begin
            o_rd_wr_en     <= 1'b0;
            o_pc_load      <= 1'b0;
            o_minstret_inc <= 1'b0;
`ifdef ASRV32_WB_TRACE_EN
            o_trace_valid  <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (i_wb_stage_en && load_defer) begin
                        op_q    <= op_in;
                        state_q <= WAIT_LOAD;
                        o_stall <= 1'b1;
                    end
                end
                WAIT_LOAD: begin
                    if (i_load_ack) begin
                        state_q <= IDLE;
                        o_stall <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    o_stall <= 1'b0;
                end
            endcase
            if (commit_go) begin
                o_rd_wr_en     <= rd_wr_en_d;
                o_rd_addr      <= op_cur.rd;
                o_rd_data      <= rd_data_d;
                o_next_pc      <= next_pc_d;
                o_pc_load      <= 1'b1;
                o_minstret_inc <= !op_cur.trap;
`ifdef ASRV32_WB_TRACE_EN
                o_trace_valid  <= 1'b1;
                o_trace_pc     <= op_cur.pc;
                o_trace_trap   <= op_cur.trap;
`endif
            end
        end
    end

endmodule
